// File: rtl/network_interface_pkg.sv
// Shared types and widths for the SWNET/LWNET network interface.
package network_interface_pkg;
  localparam int PAYLOAD_W = 32;
  localparam int DROP_W    = 8;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_e;
endpackage

// File: rtl/ni_fifo.sv
// Synchronous FIFO with wrap-bit pointers; storage is not reset, only the pointers are.
module ni_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_empty   = (r_wptr == r_rptr);
  // A push while full is only taken when the head leaves in the same cycle.
  assign w_do_push = i_push & (~o_full | i_pop);
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_dout    = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_din;
  end
endmodule

// File: rtl/network_interface.sv
// NoC node interface: SWNET -> TX FIFO -> link, link -> node filter -> RX FIFO -> LWNET.
// Optional NI_IRQ_EN adds the registered ni_irq output (RX FIFO non-empty).
module network_interface
  import network_interface_pkg::*;
#(
  parameter int NODE_ID  = 0,
  parameter int ADDR_W   = 4,
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4,
  parameter int FLIT_W   = 2*ADDR_W+32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              cpu_write,
  input  logic              cpu_read,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_rvalid,
  output logic              cpu_stall,
  output logic [FLIT_W-1:0] tx_flit,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [FLIT_W-1:0] rx_flit,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        drop_count
`ifdef NI_IRQ_EN
  ,
  output logic              ni_irq
`endif
);
  localparam logic [ADDR_W-1:0] NODE_ADDR = ADDR_W'(NODE_ID);

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  tx_state_e             r_tx_state;
  tx_state_e             w_tx_next;
  logic [FLIT_W-1:0]     r_tx_flit;
  logic [FLIT_W-1:0]     w_tx_din;
  logic [FLIT_W-1:0]     w_tx_dout;
  logic                  w_tx_full;
  logic                  w_tx_empty;
  logic                  w_tx_push;
  logic                  w_tx_pop;

  logic [PAYLOAD_W-1:0]  w_rx_dout;
  logic                  w_rx_full;
  logic                  w_rx_empty;
  logic                  w_rx_xfer;
  logic                  w_rx_match;
  logic                  w_rx_push;
  logic                  w_rx_pop;

  logic [PAYLOAD_W-1:0]  r_rdata;
  logic                  r_rvalid;
  logic [DROP_W-1:0]     r_drop;
  logic                  w_unused;

  // CPU side: write wins an illegal read+write decode.
  assign w_tx_push = cpu_write & ~w_tx_full;
  assign w_rx_pop  = cpu_read & ~w_rx_empty & ~cpu_write;
  assign cpu_stall = (cpu_write & w_tx_full) | (cpu_read & (w_rx_empty | cpu_write));
  assign w_tx_din  = {cpu_addr[ADDR_W-1:0], NODE_ADDR, cpu_wdata};

  ni_fifo #(.DEPTH(TX_DEPTH), .WIDTH(FLIT_W)) u_tx_fifo (
    .i_clk  (CLK),
    .i_rst  (RESET),
    .i_push (w_tx_push),
    .i_pop  (w_tx_pop),
    .i_din  (w_tx_din),
    .o_dout (w_tx_dout),
    .o_full (w_tx_full),
    .o_empty(w_tx_empty)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_tx_state <= TX_IDLE;
      r_tx_flit  <= '0;
    end else begin
      r_tx_state <= w_tx_next;
      if (w_tx_pop) r_tx_flit <= w_tx_dout;
    end
  end

  always_comb begin
    w_tx_next = r_tx_state;
    w_tx_pop  = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        if (!w_tx_empty) begin
          w_tx_pop  = 1'b1;
          w_tx_next = TX_SEND;
        end
      end
      TX_SEND: begin
        // Refill the output register straight away to sustain 1 flit/cycle.
        if (tx_ready) begin
          if (!w_tx_empty) w_tx_pop  = 1'b1;
          else             w_tx_next = TX_IDLE;
        end
      end
      default: w_tx_next = TX_IDLE;
    endcase
  end

  assign tx_flit  = r_tx_flit;
  assign tx_valid = (r_tx_state == TX_SEND);

  // RX side: no full bypass, so a pop does not reopen rx_ready in the same cycle.
  assign rx_ready   = ~w_rx_full;
  assign w_rx_xfer  = rx_valid & ~w_rx_full;
  assign w_rx_match = (rx_flit[FLIT_W-1 -: ADDR_W] == NODE_ADDR);
  assign w_rx_push  = w_rx_xfer & w_rx_match;

  ni_fifo #(.DEPTH(RX_DEPTH), .WIDTH(PAYLOAD_W)) u_rx_fifo (
    .i_clk  (CLK),
    .i_rst  (RESET),
    .i_push (w_rx_push),
    .i_pop  (w_rx_pop),
    .i_din  (rx_flit[PAYLOAD_W-1:0]),
    .o_dout (w_rx_dout),
    .o_full (w_rx_full),
    .o_empty(w_rx_empty)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_drop   <= '0;
    end else begin
      r_rvalid <= w_rx_pop;
      if (w_rx_pop) r_rdata <= w_rx_dout;
      if (w_rx_xfer && !w_rx_match) r_drop <= sat_inc(r_drop);
    end
  end

  assign cpu_rdata  = r_rdata;
  assign cpu_rvalid = r_rvalid;
  assign drop_count = r_drop;

`ifdef NI_IRQ_EN
  logic r_irq;

  always_ff @(posedge CLK) begin
    if (RESET) r_irq <= 1'b0;
    else       r_irq <= ~w_rx_empty;
  end

  assign ni_irq = r_irq;
`endif

  assign w_unused = ^{cpu_addr[31:ADDR_W], rx_flit[PAYLOAD_W +: ADDR_W]};
endmodule

// File: tb/tb_network_interface.sv
// Directed bench for network_interface at NODE_ID=1, ADDR_W=4, depths of 4.
module tb_network_interface;
  localparam int FW = 40;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          cpu_write, cpu_read;
  logic [31:0]   cpu_addr, cpu_wdata;
  logic [31:0]   cpu_rdata;
  logic          cpu_rvalid, cpu_stall;
  logic [FW-1:0] tx_flit;
  logic          tx_valid, tx_ready;
  logic [FW-1:0] rx_flit;
  logic          rx_valid, rx_ready;
  logic [7:0]    drop_count;
`ifdef NI_IRQ_EN
  logic          ni_irq;
`endif

  int nvec = 0;
  int nerr = 0;

  network_interface #(.NODE_ID(1), .ADDR_W(4), .TX_DEPTH(4), .RX_DEPTH(4), .FLIT_W(FW)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .cpu_write (cpu_write),
    .cpu_read  (cpu_read),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_rvalid(cpu_rvalid),
    .cpu_stall (cpu_stall),
    .tx_flit   (tx_flit),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_flit   (rx_flit),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .drop_count(drop_count)
`ifdef NI_IRQ_EN
    ,
    .ni_irq    (ni_irq)
`endif
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [FW-1:0] mkflit(input logic [3:0] d, input logic [3:0] s,
                                           input logic [31:0] p);
    return {d, s, p};
  endfunction

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1; cpu_write = 0; cpu_read = 0; cpu_addr = 0; cpu_wdata = 0;
    tx_ready = 1'b1; rx_flit = '0; rx_valid = 0;
    cyc(); cyc();
    RESET = 1'b0;
    #1;
    nvec++; if (tx_valid !== 1'b0) begin nerr++; $display("FAIL rst_tx_valid got %b want 0", tx_valid); end
    nvec++; if (tx_flit !== '0) begin nerr++; $display("FAIL rst_tx_flit got %h want 0", tx_flit); end
    nvec++; if (cpu_rdata !== 32'h0) begin nerr++; $display("FAIL rst_rdata got %h want 0", cpu_rdata); end
    nvec++; if (cpu_rvalid !== 1'b0) begin nerr++; $display("FAIL rst_rvalid got %b want 0", cpu_rvalid); end
    nvec++; if (drop_count !== 8'd0) begin nerr++; $display("FAIL rst_drop got %0d want 0", drop_count); end
    nvec++; if (rx_ready !== 1'b1) begin nerr++; $display("FAIL rst_rx_ready got %b want 1", rx_ready); end
`ifdef NI_IRQ_EN
    nvec++; if (ni_irq !== 1'b0) begin nerr++; $display("FAIL rst_irq got %b want 0", ni_irq); end
`endif
    cyc();
  endtask

  task automatic test_single_tx();
    tx_ready = 1'b1;
    cpu_write = 1'b1; cpu_addr = 32'h2; cpu_wdata = 32'hDEADBEEF;
    #1;
    nvec++; if (cpu_stall !== 1'b0) begin nerr++; $display("FAIL tx1_stall got %b want 0", cpu_stall); end
    cyc();
    cpu_write = 1'b0;
    #1;
    nvec++; if (tx_valid !== 1'b0) begin nerr++; $display("FAIL tx1_valid_n1 got %b want 0", tx_valid); end
    cyc();
    nvec++; if (tx_valid !== 1'b1) begin nerr++; $display("FAIL tx1_valid_n2 got %b want 1", tx_valid); end
    nvec++; if (tx_flit !== mkflit(4'd2, 4'd1, 32'hDEADBEEF)) begin
      nerr++; $display("FAIL tx1_flit got %h want %h", tx_flit, mkflit(4'd2, 4'd1, 32'hDEADBEEF));
    end
    cyc();
    nvec++; if (tx_valid !== 1'b0) begin nerr++; $display("FAIL tx1_valid_n3 got %b want 0", tx_valid); end
  endtask

  task automatic test_tx_backpressure();
    logic exp_stall;
    tx_ready = 1'b0;
    cpu_addr = 32'h3;
    for (int i = 0; i < 6; i++) begin
      cpu_write = 1'b1; cpu_wdata = 32'hA0000000 + i;
      #1;
      // First flit moves into the output register, so four more fill the FIFO.
      exp_stall = (i >= 5);
      nvec++; if (cpu_stall !== exp_stall) begin
        nerr++; $display("FAIL bp_stall_%0d got %b want %b", i, cpu_stall, exp_stall);
      end
      cyc();
    end
    cpu_write = 1'b0;
    nvec++; if (tx_flit !== mkflit(4'd3, 4'd1, 32'hA0000000) || tx_valid !== 1'b1) begin
      nerr++; $display("FAIL bp_hold got %h/%b want %h/1", tx_flit, tx_valid, mkflit(4'd3, 4'd1, 32'hA0000000));
    end
    tx_ready = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      nvec++; if (tx_valid !== 1'b1 || tx_flit !== mkflit(4'd3, 4'd1, 32'hA0000000 + k)) begin
        nerr++; $display("FAIL bp_drain_%0d got %h/%b want %h/1", k, tx_flit, tx_valid,
                         mkflit(4'd3, 4'd1, 32'hA0000000 + k));
      end
      cyc();
    end
    nvec++; if (tx_valid !== 1'b0) begin nerr++; $display("FAIL bp_idle got %b want 0", tx_valid); end
  endtask

  task automatic test_rx_read();
    cpu_read = 1'b1;
    rx_flit = mkflit(4'd1, 4'd3, 32'h12345678); rx_valid = 1'b1;
    #1;
    nvec++; if (cpu_stall !== 1'b1) begin nerr++; $display("FAIL rd_stall_empty got %b want 1", cpu_stall); end
    cyc();
    rx_valid = 1'b0;
    #1;
    nvec++; if (cpu_stall !== 1'b0) begin nerr++; $display("FAIL rd_stall_avail got %b want 0", cpu_stall); end
    cyc();
    cpu_read = 1'b0;
    nvec++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h12345678) begin
      nerr++; $display("FAIL rd_data got %h/%b want 12345678/1", cpu_rdata, cpu_rvalid);
    end
    cyc();
    nvec++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'h12345678) begin
      nerr++; $display("FAIL rd_hold got %h/%b want 12345678/0", cpu_rdata, cpu_rvalid);
    end
  endtask

  task automatic test_drop();
    rx_flit = mkflit(4'd5, 4'd2, 32'h0BADF00D); rx_valid = 1'b1;
    cyc();
    rx_valid = 1'b0;
    cpu_read = 1'b1;
    #1;
    nvec++; if (drop_count !== 8'd1) begin nerr++; $display("FAIL drop_one got %0d want 1", drop_count); end
    nvec++; if (cpu_stall !== 1'b1) begin nerr++; $display("FAIL drop_not_queued got %b want 1", cpu_stall); end
    cpu_read = 1'b0;
    rx_valid = 1'b1;
    for (int i = 0; i < 254; i++) cyc();
    nvec++; if (drop_count !== 8'd255) begin nerr++; $display("FAIL drop_255 got %0d want 255", drop_count); end
    for (int i = 0; i < 45; i++) cyc();
    rx_valid = 1'b0;
    nvec++; if (drop_count !== 8'd255) begin nerr++; $display("FAIL drop_sat got %0d want 255", drop_count); end
  endtask

  task automatic test_rx_full();
    for (int i = 0; i < 4; i++) begin
      rx_flit = mkflit(4'd1, 4'd4, 32'hB0 + i); rx_valid = 1'b1;
      #1;
      nvec++; if (rx_ready !== 1'b1) begin nerr++; $display("FAIL full_ready_%0d got %b want 1", i, rx_ready); end
      cyc();
    end
    rx_flit = mkflit(4'd1, 4'd4, 32'hBAD);
    #1;
    nvec++; if (rx_ready !== 1'b0) begin nerr++; $display("FAIL full_ready_low got %b want 0", rx_ready); end
    cpu_read = 1'b1;
    cyc();
    rx_valid = 1'b0;
    nvec++; if (rx_ready !== 1'b1 || cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hB0) begin
      nerr++; $display("FAIL full_pop got %b/%b/%h want 1/1/000000b0", rx_ready, cpu_rvalid, cpu_rdata);
    end
    for (int i = 1; i < 4; i++) begin
      cyc();
      nvec++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hB0 + i) begin
        nerr++; $display("FAIL full_order_%0d got %h/%b want %h/1", i, cpu_rdata, cpu_rvalid, 32'hB0 + i);
      end
    end
    #1;
    nvec++; if (cpu_stall !== 1'b1) begin nerr++; $display("FAIL full_no_overflow got %b want 1", cpu_stall); end
    cpu_read = 1'b0;
    cyc();
    nvec++; if (drop_count !== 8'd255) begin nerr++; $display("FAIL full_drop got %0d want 255", drop_count); end
  endtask

  task automatic test_collision();
    tx_ready = 1'b1;
    rx_flit = mkflit(4'd1, 4'd6, 32'hC0); rx_valid = 1'b1;
    cyc();
    rx_valid = 1'b0;
    cpu_write = 1'b1; cpu_read = 1'b1; cpu_addr = 32'h7; cpu_wdata = 32'hC1;
    #1;
    nvec++; if (cpu_stall !== 1'b1) begin nerr++; $display("FAIL col_stall got %b want 1", cpu_stall); end
    cyc();
    cpu_write = 1'b0; cpu_read = 1'b0;
    nvec++; if (cpu_rvalid !== 1'b0) begin nerr++; $display("FAIL col_no_read got %b want 0", cpu_rvalid); end
    cyc();
    nvec++; if (tx_valid !== 1'b1 || tx_flit !== mkflit(4'd7, 4'd1, 32'hC1)) begin
      nerr++; $display("FAIL col_write got %h/%b want %h/1", tx_flit, tx_valid, mkflit(4'd7, 4'd1, 32'hC1));
    end
    cpu_read = 1'b1;
    #1;
    nvec++; if (cpu_stall !== 1'b0) begin nerr++; $display("FAIL col_read_ok got %b want 0", cpu_stall); end
    cyc();
    cpu_read = 1'b0;
    nvec++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hC0) begin
      nerr++; $display("FAIL col_rdata got %h/%b want 000000c0/1", cpu_rdata, cpu_rvalid);
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    tx_ready = 1'b0;
    cpu_write = 1'b1; cpu_addr = 32'h9; cpu_wdata = 32'hD0;
    cyc();
    cpu_write = 1'b1; cpu_wdata = 32'hD1;
    rx_flit = mkflit(4'd1, 4'd2, 32'hE0); rx_valid = 1'b1;
    cyc();
    cpu_write = 1'b0;
    rx_flit = mkflit(4'd1, 4'd2, 32'hE1);
    cyc();
    rx_valid = 1'b0;
    nvec++; if (tx_valid !== 1'b1) begin nerr++; $display("FAIL mid_sending got %b want 1", tx_valid); end
`ifdef NI_IRQ_EN
    nvec++; if (ni_irq !== 1'b1) begin nerr++; $display("FAIL mid_irq_high got %b want 1", ni_irq); end
`endif
    RESET = 1'b1;
    cyc();
    RESET = 1'b0;
    nvec++; if (tx_valid !== 1'b0 || tx_flit !== '0) begin
      nerr++; $display("FAIL mid_tx_cleared got %h/%b want 0/0", tx_flit, tx_valid);
    end
    nvec++; if (rx_ready !== 1'b1) begin nerr++; $display("FAIL mid_rx_ready got %b want 1", rx_ready); end
`ifdef NI_IRQ_EN
    nvec++; if (ni_irq !== 1'b0) begin nerr++; $display("FAIL mid_irq_low got %b want 0", ni_irq); end
`endif
    cpu_read = 1'b1; tx_ready = 1'b1;
    #1;
    nvec++; if (cpu_stall !== 1'b1) begin nerr++; $display("FAIL mid_read_stall got %b want 1", cpu_stall); end
    cpu_read = 1'b0;
    cyc(); cyc(); cyc();
    nvec++; if (tx_valid !== 1'b0) begin nerr++; $display("FAIL mid_no_replay got %b want 0", tx_valid); end
  endtask

  initial begin
    test_reset();
    test_single_tx();
    test_tx_backpressure();
    test_rx_read();
    test_drop();
    test_rx_full();
    test_collision();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
